// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - rebuilds LSB-first WIDTH-bit words from a serial_in/start_in stream.
// Optional DESER_INPUT_SYNC_EN puts a 2-flop synchronizer on both inputs (+2 clk latency).
module serial_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             start_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-2:0] shreg;
  logic             ser;
  logic             start;

`ifdef DESER_INPUT_SYNC_EN
  logic [1:0] ser_sync;
  logic [1:0] start_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ser_sync   <= 2'b00;
      start_sync <= 2'b00;
    end else begin
      ser_sync   <= {ser_sync[0], serial_in};
      start_sync <= {start_sync[0], start_in};
    end
  end

  assign ser   = ser_sync[1];
  assign start = start_sync[1];
`else
  assign ser   = serial_in;
  assign start = start_in;
`endif

  // The final bit never lands in shreg; it goes straight into data_out with the rest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= '0;
            shreg[0] <= ser;
            bit_cnt  <= BW'(1);
            state    <= SHIFT;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          if (start) begin
            frame_err <= 1'b1;
            if (err_count != {CNT_W{1'b1}}) begin
              err_count <= err_count + 1'b1;
            end
            shreg    <= '0;
            shreg[0] <= ser;
            bit_cnt  <= BW'(1);
          end else if (bit_cnt == LAST_BIT) begin
            data_out   <= {ser, shreg};
            data_valid <= 1'b1;
            bit_cnt    <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
          end else begin
            shreg[bit_cnt] <= ser;
            bit_cnt        <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - randomized and directed bench for serial_deserializer against a queue-based frame model.
module tb_serial_deserializer;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
`ifdef DESER_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             serial_in = 1'b0;
  logic             start_in = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic             frame_err;
  logic [CNT_W-1:0] err_count;

  serial_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .start_in(start_in),
    .data_out(data_out), .data_valid(data_valid), .busy(busy),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a frame is just the list of bits collected since the last start.
  bit               q_s[$];
  bit               q_d[$];
  bit               bits[$];
  bit               in_frame;
  logic [WIDTH-1:0] exp_data;
  logic             exp_valid, exp_err, exp_busy;
  logic [CNT_W-1:0] exp_cnt;
  bit               armed = 1'b0;

  task automatic model_reset();
    q_s.delete(); q_d.delete(); bits.delete();
    for (int i = 0; i < LAT; i++) begin q_s.push_back(1'b0); q_d.push_back(1'b0); end
    in_frame = 0; exp_data = '0; exp_valid = 0; exp_err = 0; exp_busy = 0; exp_cnt = '0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit d);
    bit es, ed;
    if (!r) begin model_reset(); return; end
    q_s.push_back(s); q_d.push_back(d);
    es = q_s.pop_front(); ed = q_d.pop_front();
    exp_valid = 0; exp_err = 0;
    if (es) begin
      if (in_frame) begin
        exp_err = 1;
        if (exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
      end
      bits.delete(); bits.push_back(ed); in_frame = 1;
    end else if (in_frame) begin
      bits.push_back(ed);
      if (bits.size() == WIDTH) begin
        exp_data = '0;
        for (int i = 0; i < WIDTH; i++) if (bits[i]) exp_data = exp_data + (WIDTH'(1) << i);
        exp_valid = 1; in_frame = 0; bits.delete();
      end
    end
    exp_busy = in_frame;
  endtask

  task automatic cycle(input bit r, input bit s, input bit d);
    rst_n = r; start_in = s; serial_in = d;
    @(posedge clk);
    model_step(r, s, d);
    armed = 1'b1;
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) cycle(1'b1, i == 0, w[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("data_out", 32'(data_out), 32'(exp_data));
      check("data_valid", 32'(data_valid), 32'(exp_valid));
      check("busy", 32'(busy), 32'(exp_busy));
      check("frame_err", 32'(frame_err), 32'(exp_err));
      check("err_count", 32'(err_count), 32'(exp_cnt));
    end
  end

  initial begin
    model_reset();
    // reset with toggling inputs
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'(i & 1), 1'(~i & 1));
    check("reset_data", 32'(data_out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_cnt", 32'(err_count), 32'h0);

    // single frame 0xA5
    send_word(8'hA5, WIDTH);
    idle(LAT);
    check("a5_valid", 32'(data_valid), 32'h1);
    check("a5_data", 32'(data_out), 32'hA5);
    idle(1);
    check("a5_pulse_len", 32'(data_valid), 32'h0);
    idle(3);

    // back-to-back 0x3C, 0xC3
    send_word(8'h3C, WIDTH);
    send_word(8'hC3, WIDTH);
    idle(LAT);
    check("b2b_data", 32'(data_out), 32'hC3);
    check("b2b_valid", 32'(data_valid), 32'h1);
    check("b2b_cnt", 32'(err_count), 32'h0);
    idle(2);

    // early start after 4 bits, then 0x81
    send_word(8'hFF, 4);
    send_word(8'h81, WIDTH);
    idle(LAT);
    check("abort_cnt", 32'(err_count), 32'h1);
    check("abort_data", 32'(data_out), 32'h81);
    idle(2);

    // abort on the final-bit cycle
    send_word(8'h7E, WIDTH - 1);
    send_word(8'h42, WIDTH);
    idle(LAT + 2);
    check("lastbit_abort_cnt", 32'(err_count), 32'h2);
    check("lastbit_abort_data", 32'(data_out), 32'h42);

    // saturation
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)));
    idle(3);
    send_word(8'hFF, WIDTH);
    idle(LAT);
    check("sat_valid", 32'(data_valid), 32'h1);
    check("sat_data", 32'(data_out), 32'hFF);
    check("sat_cnt", 32'(err_count), 32'hFF);
    idle(2);

    // reset mid-frame, then 0x5A
    send_word(8'hE7, 4);
    cycle(1'b0, 1'b0, 1'b1);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_cnt", 32'(err_count), 32'h0);
    send_word(8'h5A, WIDTH);
    idle(LAT);
    check("midrst_data", 32'(data_out), 32'h5A);
    check("midrst_valid", 32'(data_valid), 32'h1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else cycle(1'b1, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    end
    // random complete frames, some back-to-back
    for (int i = 0; i < 100; i++) begin
      send_word(WIDTH'($urandom), WIDTH);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(LAT + 2);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
